// File: rtl/alu_pkg.sv
// Shared ALU types: funct3-encoded opcode enum and the request bundle
// that is routed from the winning requester to the shared ALU.
package alu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SLL  = 3'd1,
    ALU_SLT  = 3'd2,
    ALU_SLTU = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SR   = 3'd5,
    ALU_OR   = 3'd6,
    ALU_AND  = 3'd7
  } alu_op_t;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_op_t         op;
    logic            rev;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit integer ALU; rev selects sub for add and
// arithmetic shift for the right-shift opcode.
module alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_t         op,
  input  logic            rev,
  output logic [XLEN-1:0] y
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  always_comb begin
    y = '0;
    unique case (op)
      ALU_ADD:  y = rev ? (a - b) : (a + b);
      ALU_SLL:  y = a << shamt;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  y = a ^ b;
      ALU_SR:   y = rev ? $unsigned($signed(a) >>> shamt) : (a >> shamt);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin with a one-bit priority pointer, or fixed
// priority (port 0 wins ties) when FAIR is 0.
module rr_arb2 #(
  parameter int unsigned FAIR      = 1,
  parameter int unsigned INIT_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] elig,
  output logic [1:0] win
);

  localparam logic INIT_BIT = (INIT_PRIO != 0);
  localparam logic FAIR_BIT = (FAIR != 0);

  logic prio;

  always_comb begin
    win = elig;
    if (elig == 2'b11) begin
      win = (FAIR_BIT && prio) ? 2'b10 : 2'b01;
    end
  end

  // Pointer hands priority to the port that did not just win.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= INIT_BIT;
    end else if (FAIR_BIT && (win != 2'b00)) begin
      prio <= win[0];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters; each port owns a
// one-entry result buffer loaded the edge its request is accepted.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned FAIR      = 1,
  parameter int unsigned INIT_PRIO = 0
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            r0_valid,
  output logic            r0_ready,
  input  logic [XLEN-1:0] r0_a,
  input  logic [XLEN-1:0] r0_b,
  input  logic [2:0]      r0_op,
  input  logic            r0_rev,
  output logic            r0_resp_valid,
  input  logic            r0_resp_ready,
  output logic [XLEN-1:0] r0_result,

  input  logic            r1_valid,
  output logic            r1_ready,
  input  logic [XLEN-1:0] r1_a,
  input  logic [XLEN-1:0] r1_b,
  input  logic [2:0]      r1_op,
  input  logic            r1_rev,
  output logic            r1_resp_valid,
  input  logic            r1_resp_ready,
  output logic [XLEN-1:0] r1_result,

  output logic [1:0]      grant
);

  alu_req_t        req0;
  alu_req_t        req1;
  alu_req_t        sel;
  logic [1:0]      elig;
  logic [1:0]      win;
  logic            full0;
  logic            full1;
  logic [XLEN-1:0] alu_y;

  always_comb begin
    req0.a   = r0_a;
    req0.b   = r0_b;
    req0.op  = alu_op_t'(r0_op);
    req0.rev = r0_rev;
    req1.a   = r1_a;
    req1.b   = r1_b;
    req1.op  = alu_op_t'(r1_op);
    req1.rev = r1_rev;
  end

  // Buffers read as empty during reset so ready reflects the post-reset view.
  assign full0   = r0_resp_valid & ~reset;
  assign full1   = r1_resp_valid & ~reset;
  assign elig[0] = r0_valid & (~full0 | r0_resp_ready);
  assign elig[1] = r1_valid & (~full1 | r1_resp_ready);

  rr_arb2 #(
    .FAIR      (FAIR),
    .INIT_PRIO (INIT_PRIO)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .elig  (elig),
    .win   (win)
  );

  assign r0_ready = win[0];
  assign r1_ready = win[1];
  assign sel      = win[1] ? req1 : req0;

  alu u_alu (
    .a   (sel.a),
    .b   (sel.b),
    .op  (sel.op),
    .rev (sel.rev),
    .y   (alu_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r0_resp_valid <= 1'b0;
      r0_result     <= '0;
      r1_resp_valid <= 1'b0;
      r1_result     <= '0;
      grant         <= 2'b00;
    end else begin
      grant <= win;
      if (win[0]) begin
        r0_result     <= alu_y;
        r0_resp_valid <= 1'b1;
      end else if (r0_resp_ready && r0_resp_valid) begin
        r0_resp_valid <= 1'b0;
      end
      if (win[1]) begin
        r1_result     <= alu_y;
        r1_resp_valid <= 1'b1;
      end else if (r1_resp_ready && r1_resp_valid) begin
        r1_resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one `alu` instance between two independent requesters, e.g. the execute stage (port 0) and an address/branch-target unit (port 1).
- Each port has a valid/ready request channel carrying operands and opcode, and a valid/ready response channel with a one-entry result buffer.
- Arbitration is round-robin (or fixed priority by parameter).
- The ALU result is registered into the winner's response buffer one cycle after acceptance.

Parameters:
- FAIR, 1: 1 = round-robin between ports; 0 = fixed priority, port 0 always wins ties.
- INIT_PRIO, 0: port holding priority after reset (round-robin mode only); legal values 0 or 1.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- r0_valid  input  1  port 0 request valid
- r0_ready  output  1  port 0 request accepted this cycle when r0_valid & r0_ready
- r0_a  input  32  port 0 operand A
- r0_b  input  32  port 0 operand B
- r0_op  input  3  port 0 opcode (funct3 encoding: 0 add/sub, 1 sll, 2 slt, 3 sltu, 4 xor, 5 srl/sra, 6 or, 7 and)
- r0_rev  input  1  port 0 sub/arith-shift select
- r0_resp_valid  output  1  port 0 result buffer full
- r0_resp_ready  input  1  port 0 consumer takes result
- r0_result  output  32  port 0 buffered result
- r1_valid, r1_ready, r1_a, r1_b, r1_op, r1_rev, r1_resp_valid, r1_resp_ready, r1_result: identical widths and meanings for port 1
- grant  output  2  one-hot, registered; bit i set the cycle after port i was accepted (debug/perf)

Behaviour:
- Reset (synchronous): rN_resp_valid=0, rN_result=0, grant=0, priority pointer=INIT_PRIO. Any in-flight result is dropped. rN_ready is combinational and evaluates with empty buffers in the reset cycle, but no acceptance takes effect while reset=1.
- Eligibility: port i is eligible iff ri_valid & (~ri_resp_valid | ri_resp_ready). A full buffer that is drained in the same cycle frees the slot.
- Selection (combinational, same cycle):
  - If exactly one port is eligible, it wins.
  - If both are eligible, the priority holder wins (FAIR=1) or port 0 wins (FAIR=0).
- rN_ready = 1 only for the winner; at most one ready per cycle. Ready may depend on valid. Requesters must hold operands stable while valid & ~ready.
- The ALU inputs are muxed from the winner's a/b/op/rev. When no port wins, the ALU inputs are driven with port 0's fields; the output is unused.
- Latency: request accepted at edge N → ri_result and ri_resp_valid=1 visible after edge N. Exactly 1 cycle, zero bubbles. Back-to-back acceptance on the same port is allowed if its consumer drains each cycle.
- Result buffer per port, at each edge:
  - accepted → load ALU result, valid=1 (overrides a simultaneous drain).
  - else if resp_ready & resp_valid → valid=0 (result data holds its last value).
  - else hold.
- Priority pointer (FAIR=1): after a grant to port i, the pointer moves to the other port. With no grant, the pointer holds.
- grant register: loads the one-hot of the winner each edge, 0 if none.
- Arithmetic: full 32-bit, wrap-around (0xFFFFFFFF + 1 = 0). Shift amount is b[4:0] only. No overflow flag.
- resp_ready while resp_valid=0 has no effect.

Decomposition:
- Shared package `alu_pkg`:
  - typedef `alu_op_t` (3-bit enum: ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SR, ALU_OR, ALU_AND)
  - struct `alu_req_t` {a, b, op, rev}
- Sub-modules:
  - `alu` instantiated once, unmodified.
  - One natural new sub-module: `rr_arb2`, a 2-way arbiter with FAIR/INIT_PRIO, eligibility inputs, one-hot win output and pointer state.
  - Response buffers stay inline.

Test Plan:
- Port 0 only: add 5+7, rev=0 → r0_ready=1 in the same cycle; next cycle r0_resp_valid=1, r0_result=12; grant=2'b01.
- Both valid after reset with FAIR=1, INIT_PRIO=0; port 0 sub 3-5 (rev=1), port 1 sra 0x80000000 by 4 (op=5, rev=1); both consumers always ready → cycle 0 port 0 wins, r0_result=0xFFFFFFFE; cycle 1 port 1 wins, r1_result=0xF8000000; alternation continues.
- Backpressure: r0_resp_ready=0 with r0_result valid and new r0_valid → r0_ready=0, port 1 is granted instead. Raising r0_resp_ready → port 0 accepted in that same cycle, buffer reloads with no bubble.
- FAIR=0, both valid continuously, consumers always ready → port 1 never granted; r1_ready stays 0.
- Boundary ops: sltu 0xFFFFFFFF<1 → 0; slt 0xFFFFFFFF<1 → 1; add 0xFFFFFFFF+1 → 0; sll 1 by b=33 → 2.
- Reset mid-operation: assert reset in the cycle after acceptance with resp_valid=1 and resp_ready=0 → next cycle both resp_valid=0 and grant=0; first post-reset contention goes to port INIT_PRIO.
